// File: rtl/divider_pkg.sv
// divider_pkg: shared width, state encoding and divide-by-zero quotient for divider_34b.
package divider_pkg;
   localparam int W = 34;
   localparam int CNT_W = $clog2(W);
   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
   localparam logic [W-1:0] DBZ_QUOT = '1;
endpackage

// File: rtl/divider_34b_cu.sv
// divider_34b_cu: FSM, iteration counter and handshake for the restoring divider.
module divider_34b_cu
   import divider_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic b_zero,
   output logic busy,
   output logic done,
   output logic load,
   output logic shift,
   output logic last
);
   state_t state;
   logic [CNT_W-1:0] cnt;
   assign load  = state == IDLE && start;
   assign shift = state == BUSY;
   assign last  = shift && cnt == CNT_W'(W - 1);
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else
         case (state)
            IDLE: if (start) begin
               state <= b_zero ? DONE : BUSY;
               cnt   <= '0;
               busy  <= 1'b1;
               done  <= b_zero;
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
endmodule

// File: rtl/divider_34b.sv
// divider_34b: sequential 34-bit unsigned restoring divider, one quotient bit per clock.
// DIVIDER_34B_DBZ_EN adds the div_by_zero flag output.
module divider_34b
   import divider_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] q,
   output logic [W-1:0] r
`ifdef DIVIDER_34B_DBZ_EN
   ,output logic        div_by_zero
`endif
);
   logic load, shift, last, b_zero;
   logic [W:0] rem, rem_sh, diff, nrem;
   logic [W-1:0] qsh, dvs, nq;
   assign b_zero = b == '0;
   divider_34b_cu u_cu (
      .clk(clk), .rst(rst), .start(start), .b_zero(b_zero),
      .busy(busy), .done(done), .load(load), .shift(shift), .last(last)
   );
   // A borrow out of the W+1 bit subtraction means the divisor did not fit.
   assign rem_sh = {rem[W-1:0], qsh[W-1]};
   assign diff   = rem_sh - {1'b0, dvs};
   assign nrem   = diff[W] ? rem_sh : diff;
   assign nq     = {qsh[W-2:0], ~diff[W]};
   always_ff @(posedge clk)
      if (rst) begin
         rem <= '0;
         qsh <= '0;
         dvs <= '0;
         q   <= '0;
         r   <= '0;
      end else if (load) begin
         rem <= '0;
         qsh <= a;
         dvs <= b;
         if (b_zero) begin
            q <= DBZ_QUOT;
            r <= a;
         end
      end else if (shift) begin
         rem <= nrem;
         qsh <= nq;
         if (last) begin
            q <= nq;
            r <= nrem[W-1:0];
         end
      end
`ifdef DIVIDER_34B_DBZ_EN
   always_ff @(posedge clk)
      if (rst) div_by_zero <= 1'b0;
      else if (load) div_by_zero <= b_zero;
`endif
endmodule

// File: tb/tb_divider_34b.sv
// tb_divider_34b: directed and random checks of divider_34b against an arithmetic model.
// Builds with or without DIVIDER_34B_DBZ_EN.
module tb_divider_34b;
   import divider_pkg::*;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic busy, done;
   logic [W-1:0] q, r;
   int total = 0, bad = 0;
`ifdef DIVIDER_34B_DBZ_EN
   logic dbz;
`endif
   divider_34b dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .q(q), .r(r)
`ifdef DIVIDER_34B_DBZ_EN
      ,.div_by_zero(dbz)
`endif
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd();
      return W'({$urandom, $urandom});
   endfunction

   // Issue one operation and check latency, busy, results, the single done pulse and hold.
   task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb, input string tag);
      int n;
      logic busy_ok;
      logic [W-1:0] eq, er;
      eq = (tb == '0) ? '1 : ta / tb;
      er = (tb == '0) ? ta : ta % tb;
      @(negedge clk);
      a = ta; b = tb; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = rnd(); b = rnd();
`ifdef DIVIDER_34B_DBZ_EN
      chk({tag, "_dbz"}, 64'(dbz), 64'(tb == '0));
`endif
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 200) begin
         busy_ok &= busy;
         @(negedge clk);
         n++;
      end
      busy_ok &= busy;
      chk({tag, "_lat"}, 64'(n), (tb == '0) ? 64'd0 : 64'(W));
      chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
      chk({tag, "_q"}, 64'(q), 64'(eq));
      chk({tag, "_r"}, 64'(r), 64'(er));
      @(negedge clk);
      chk({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
      chk({tag, "_hold"}, {q, r}, {eq, er});
   endtask

   initial begin
      int pulses;
      logic [W-1:0] ra, rb;
      repeat (2) @(negedge clk);
      chk("rst_state", {q, r, busy, done}, 64'd0);
`ifdef DIVIDER_34B_DBZ_EN
      chk("rst_dbz", 64'(dbz), 64'd0);
`endif
      rst = 1'b0;
      run(34'd100, 34'd7, "t1");
      run(34'h3_FFFF_FFFF, 34'd1, "t2");
      run(34'd5, 34'd9, "t3a");
      run(34'h2_0000_0000, 34'h3_0000_0001, "t3b");
      run(34'd123, 34'd0, "t4");
      run(34'd40, 34'd6, "t4_clear");
      // Reset in the middle of an operation drops it silently.
      @(negedge clk);
      a = 34'd100; b = 34'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         pulses += int'(done);
         @(negedge clk);
      end
      chk("t5_nodone", 64'(pulses), 64'd0);
      chk("t5_state", {q, r, busy, done}, 64'd0);
      run(34'd81, 34'd9, "t5_after");
      // A start during BUSY is ignored.
      @(negedge clk);
      a = 34'd100; b = 34'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      a = 34'd50; b = 34'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         pulses += int'(done);
         @(negedge clk);
      end
      chk("t6_pulses", 64'(pulses), 64'd1);
      chk("t6_q", 64'(q), 64'd14);
      chk("t6_r", 64'(r), 64'd2);
      for (int i = 0; i < 1200; i++) begin
         ra = rnd() >> $urandom_range(0, 33);
         rb = ($urandom_range(0, 99) < 5) ? '0 : rnd() >> $urandom_range(0, 33);
         run(ra, rb, "rand");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
